// File: rtl/frequency_delayer_1hz.sv
// Divides the system clock down to a 50%-duty square wave (1 Hz at defaults)
// and emits a one-clk tick on every rising edge of that wave.
module frequency_delayer_1hz #(
  parameter int CLK_FREQ_HZ = 100,
  parameter int OUT_FREQ_HZ = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic out,
  output logic tick
);

  // Guarded so a zero output frequency reaches the fatal check below instead of a divide-by-zero.
  localparam int HALF_COUNT = (OUT_FREQ_HZ > 0) ? CLK_FREQ_HZ / (2 * OUT_FREQ_HZ) : 1;
  localparam int CNT_W      = (HALF_COUNT > 1) ? $clog2(HALF_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_COUNT - 1);

  if (OUT_FREQ_HZ <= 0 || CLK_FREQ_HZ < 2 * OUT_FREQ_HZ) begin : g_param_check
    $fatal(1, "frequency_delayer_1hz: need OUT_FREQ_HZ>0 and CLK_FREQ_HZ>=2*OUT_FREQ_HZ");
  end

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             out_reg, out_next;
  logic             tick_reg, tick_next;

  always_comb begin
    cnt_next  = cnt_reg;
    out_next  = out_reg;
    tick_next = 1'b0;
    if (en) begin
      if (cnt_reg == LAST) begin
        cnt_next  = '0;
        out_next  = ~out_reg;
        // Tick only on the low-to-high transition of the divided wave.
        tick_next = ~out_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      out_reg  <= 1'b0;
      tick_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      out_reg  <= out_next;
      tick_reg <= tick_next;
    end
  end

  assign out  = out_reg;
  assign tick = tick_reg;

endmodule

// File: tb/tb_frequency_delayer_1hz.sv
// Directed bench for frequency_delayer_1hz: default build plus three parameter
// variants driven in lockstep, checked against a closed-form enabled-edge model.
module tb_frequency_delayer_1hz;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  wire [3:0] out_v;
  wire [3:0] tick_v;

  always #5 clk = ~clk;

  // [0] defaults, [1] 1000/10, [2] 2/1, [3] 101/1 (truncates to 50)
  frequency_delayer_1hz #(.CLK_FREQ_HZ(100),  .OUT_FREQ_HZ(1))  dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .out(out_v[0]), .tick(tick_v[0]));
  frequency_delayer_1hz #(.CLK_FREQ_HZ(1000), .OUT_FREQ_HZ(10)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .out(out_v[1]), .tick(tick_v[1]));
  frequency_delayer_1hz #(.CLK_FREQ_HZ(2),    .OUT_FREQ_HZ(1))  dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .out(out_v[2]), .tick(tick_v[2]));
  frequency_delayer_1hz #(.CLK_FREQ_HZ(101),  .OUT_FREQ_HZ(1))  dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .out(out_v[3]), .tick(tick_v[3]));

  typedef struct {
    string      tag;
    logic [3:0] out;
    logic [3:0] tick;
  } exp_t;

  exp_t sb[$];
  int   half [4] = '{50, 50, 1, 50};
  int   total = 0;
  int   bad = 0;
  int   ecount = 0;   // enabled edges since the last reset edge
  bit   last_en = 1'b0;
  int   edge_no = 0;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_no, obs, exp_v);
    end
  endtask

  // Drive one clk edge, push the expectation, then pop and compare after the edge.
  task automatic step(input logic r, input logic e, input string tag);
    exp_t x;
    rst_n = r;
    en    = e;
    if (!r) begin
      ecount  = 0;
      last_en = 1'b0;
    end else if (e) begin
      ecount++;
      last_en = 1'b1;
    end else begin
      last_en = 1'b0;
    end
    x.tag = tag;
    for (int i = 0; i < 4; i++) begin
      x.out[i]  = ((ecount / half[i]) % 2) == 1;
      x.tick[i] = last_en && ((ecount % (2 * half[i])) == half[i]);
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    edge_no++;
    x = sb.pop_front();
    $display("edge %0d %s rst_n=%b en=%b out=%b tick=%b", edge_no, x.tag, r, e, out_v, tick_v);
    check({x.tag, ".out"}, out_v, x.out);
    check({x.tag, ".tick"}, tick_v, x.tick);
  endtask

  initial begin
    // Reset held for 3 edges with en high: reset must win.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "reset");

    // Free run 200 edges (2000 ms): default rises at 50/150, falls at 100/200.
    for (int i = 0; i < 200; i++) step(1'b1, 1'b1, "freerun");

    // Freeze after edge 30 for 20 edges; first rise moves to edge 70.
    step(1'b0, 1'b1, "reset");
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, "prefreeze");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, "freeze");
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, "resume");

    // Mid-period reset on edge 75 while out is high.
    step(1'b0, 1'b1, "reset");
    for (int i = 0; i < 74; i++) step(1'b1, 1'b1, "premid");
    step(1'b0, 1'b1, "midreset");
    for (int i = 0; i < 60; i++) step(1'b1, 1'b1, "after_rst");

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard leftover=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
